calc_engine: RTL and testbench

Parametrised hex-entry calculator core. Accepts decoded keypad events (digit, operator, equals), maintains the entry/result register shown on the display, and evaluates add, subtract and multiply over a configurable digit count. Multiply is iterative shift-add, so results carry a busy handshake. Sits between the keypad decoder and the display driver.

---
 rtl/calc_if.sv | 26 ++
 rtl/calc_engine.sv | 142 ++++++++++++++
 tb/tb_calc_engine.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/calc_if.sv
// Keypad-event and display bundle between the keypad decoder, the calculator
// core and the display driver.
interface calc_if #(
    parameter int DIGITS = 4
);
    localparam int W = 4 * DIGITS;

    logic         newhex;
    logic [3:0]   hexcode;
    logic         newop;
    logic [1:0]   opcode;
    logic         eq;
    logic [W-1:0] display;
    logic         busy;
    logic         ovf;

    modport master (
        output newhex, hexcode, newop, opcode, eq,
        input  display, busy, ovf
    );

    modport slave (
        input  newhex, hexcode, newop, opcode, eq,
        output display, busy, ovf
    );
endinterface

// File: rtl/calc_engine.sv
// Hex-entry calculator core: digit entry, add/subtract in one cycle and an
// iterative shift-add multiply guarded by busy.
module calc_engine #(
    parameter  int DIGITS = 4,
    localparam int W      = 4 * DIGITS
) (
    input  logic clock,
    input  logic reset,
    calc_if.slave kp
);
    localparam int CW = $clog2(W) + 1;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_MUL = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;

    typedef enum logic [1:0] {IDLE, MUL, WB} state_t;

    state_t          state, state_nxt;
    logic [W-1:0]    disp, opa, opb, mcand;
    logic [1:0]      pop;
    logic            pvalid, flow, ovf;
    logic [2*W-1:0]  prod;
    logic [CW-1:0]   cnt;

    logic            do_eval, start_mul;
    logic [1:0]      eval_op;
    logic [W-1:0]    left, right;
    logic [W:0]      alu_res, mul_sum;

    // Bit W of the result is the carry for add and the borrow for subtract.
    function automatic logic [W:0] alu(input logic [1:0] op,
                                       input logic [W-1:0] l,
                                       input logic [W-1:0] r);
        case (op)
            OP_ADD:  return {1'b0, l} + {1'b0, r};
            OP_SUB:  return {1'b0, l} - {1'b0, r};
            OP_MUL:  return '0;
            default: return {1'b0, r};
        endcase
    endfunction

    // Event decode: eq outranks newop, which outranks newhex.
    always_comb begin
        do_eval = 1'b0;
        eval_op = pop;
        left    = opa;
        right   = disp;
        if (state == IDLE) begin
            if (kp.eq) begin
                if (pvalid && !flow) begin
                    do_eval = 1'b1;
                end else if (pvalid && flow) begin
                    do_eval = 1'b1;
                    left    = disp;
                    right   = opb;
                end
            end else if (kp.newop) begin
                do_eval = pvalid && !flow;
            end
        end
        start_mul = do_eval && (eval_op == OP_MUL);
        alu_res   = alu(eval_op, left, right);
        mul_sum   = {1'b0, prod[2*W-1:W]} + (prod[0] ? {1'b0, mcand} : '0);
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_mul) state_nxt = MUL;
            MUL:     if (cnt == CW'(W - 1)) state_nxt = WB;
            WB:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            disp   <= '0;
            opa    <= '0;
            opb    <= '0;
            mcand  <= '0;
            prod   <= '0;
            cnt    <= '0;
            pop    <= OP_ADD;
            pvalid <= 1'b0;
            flow   <= 1'b1;
            ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (kp.eq) begin
                        flow <= 1'b1;
                        if (pvalid && !flow) opb <= disp;
                    end else if (kp.newop) begin
                        pop    <= kp.opcode;
                        pvalid <= 1'b1;
                        flow   <= 1'b1;
                        if (do_eval) opb <= disp;
                        else         opa <= disp;
                    end else if (kp.newhex) begin
                        disp <= flow ? {{(W-4){1'b0}}, kp.hexcode}
                                     : {disp[W-5:0], kp.hexcode};
                        flow <= 1'b0;
                        ovf  <= 1'b0;
                    end
                    // do_eval only fires on eq/newop, so it never races the digit path.
                    if (do_eval) begin
                        if (start_mul) begin
                            mcand <= left;
                            prod  <= {{W{1'b0}}, right};
                            cnt   <= '0;
                        end else begin
                            disp <= alu_res[W-1:0];
                            opa  <= alu_res[W-1:0];
                            ovf  <= alu_res[W];
                        end
                    end
                end
                MUL: begin
                    prod <= {mul_sum, prod[W-1:1]};
                    cnt  <= cnt + 1'b1;
                end
                WB: begin
                    disp <= prod[W-1:0];
                    opa  <= prod[W-1:0];
                    ovf  <= |prod[2*W-1:W];
                end
                default: ;
            endcase
        end
    end

    assign kp.display = disp;
    assign kp.busy    = (state != IDLE);
    assign kp.ovf     = ovf;
endmodule

// File: tb/tb_calc_engine.sv
// Directed bench for calc_engine: digit entry, add/sub/multiply, chaining,
// repeat-equals, event priority and reset during multiply.
module tb_calc_engine;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    calc_if #(.DIGITS(4)) kp();

    calc_engine #(.DIGITS(4)) dut (
        .clock (clock),
        .reset (reset),
        .kp    (kp)
    );

    always #5 clock = ~clock;

    task automatic press_hex(input logic [3:0] d);
        @(negedge clock); kp.newhex = 1'b1; kp.hexcode = d;
        @(negedge clock); kp.newhex = 1'b0;
    endtask

    task automatic press_op(input logic [1:0] op);
        @(negedge clock); kp.newop = 1'b1; kp.opcode = op;
        @(negedge clock); kp.newop = 1'b0;
    endtask

    task automatic press_eq();
        @(negedge clock); kp.eq = 1'b1;
        @(negedge clock); kp.eq = 1'b0;
    endtask

    task automatic enter(input logic [15:0] v, input int ndig);
        for (int i = ndig - 1; i >= 0; i--) press_hex(v[4*i +: 4]);
    endtask

    task automatic do_reset();
        @(negedge clock); reset = 1'b1;
        @(negedge clock); reset = 1'b0;
    endtask

    // Counts busy cycles (bounded), checking the display holds; optionally
    // pulses a digit and eq mid-multiply, which must be dropped.
    task automatic wait_busy(input logic [15:0] held, input bit inject,
                             output int n, output bit held_ok);
        n = 0;
        held_ok = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (!kp.busy) break;
            n++;
            if (kp.display !== held) held_ok = 1'b0;
            kp.hexcode = 4'h9;
            kp.newhex  = inject && (n == 3);
            kp.eq      = inject && (n == 6);
            @(negedge clock);
        end
        kp.newhex = 1'b0;
        kp.eq     = 1'b0;
    endtask

    task automatic test_reset();
        vectors++;
        if (kp.display !== 16'h0000 || kp.busy !== 1'b0 || kp.ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: display=%h busy=%b ovf=%b, need 0000/0/0", kp.display, kp.busy, kp.ovf);
        end
    endtask

    task automatic test_digits();
        logic [15:0] exp_d [5] = '{16'h0001, 16'h0012, 16'h0123, 16'h1234, 16'h2345};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            press_hex(4'(i + 1));
            vectors++;
            if (kp.display !== exp_d[i] || kp.ovf !== 1'b0) begin
                miscompares++;
                $display("FAIL digit%0d: display=%h ovf=%b, need %h/0", i + 1, kp.display, kp.ovf, exp_d[i]);
            end
        end
    endtask

    task automatic test_add_repeat();
        logic [15:0] exp_d [3] = '{16'h0100, 16'h0101, 16'h0102};
        do_reset();
        enter(16'h00FF, 2);
        press_op(2'b00);
        press_hex(4'h1);
        for (int i = 0; i < 3; i++) begin
            press_eq();
            vectors++;
            if (kp.display !== exp_d[i] || kp.ovf !== 1'b0 || kp.busy !== 1'b0) begin
                miscompares++;
                $display("FAIL add_eq%0d: display=%h ovf=%b busy=%b, need %h/0/0", i, kp.display, kp.ovf, kp.busy, exp_d[i]);
            end
        end
    endtask

    task automatic test_add_carry();
        do_reset();
        enter(16'hFFFF, 4);
        press_op(2'b00);
        press_hex(4'h2);
        press_eq();
        vectors++;
        if (kp.display !== 16'h0001 || kp.ovf !== 1'b1) begin
            miscompares++;
            $display("FAIL add_carry: display=%h ovf=%b, need 0001/1", kp.display, kp.ovf);
        end
        press_hex(4'h7);
        vectors++;
        if (kp.display !== 16'h0007 || kp.ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_clear: display=%h ovf=%b, need 0007/0", kp.display, kp.ovf);
        end
    endtask

    task automatic test_multiply();
        int n;
        bit held_ok;
        do_reset();
        enter(16'h0012, 2);
        press_op(2'b01);
        enter(16'h0034, 2);
        press_eq();
        wait_busy(16'h0034, 1'b1, n, held_ok);
        vectors++;
        if (n != 17 || !held_ok) begin
            miscompares++;
            $display("FAIL mul_busy: busy_cycles=%0d held=%b, need 17/1", n, held_ok);
        end
        vectors++;
        if (kp.display !== 16'h03A8 || kp.ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL mul_12x34: display=%h ovf=%b, need 03A8/0", kp.display, kp.ovf);
        end
        do_reset();
        enter(16'hFFFF, 4);
        press_op(2'b01);
        press_hex(4'h2);
        press_eq();
        wait_busy(16'h0002, 1'b0, n, held_ok);
        vectors++;
        if (kp.display !== 16'hFFFE || kp.ovf !== 1'b1 || n != 17) begin
            miscompares++;
            $display("FAIL mul_ffffx2: display=%h ovf=%b cycles=%0d, need FFFE/1/17", kp.display, kp.ovf, n);
        end
    endtask

    task automatic test_subtract();
        do_reset();
        press_hex(4'h5);
        press_op(2'b10);
        press_hex(4'h7);
        press_eq();
        vectors++;
        if (kp.display !== 16'hFFFE || kp.ovf !== 1'b1) begin
            miscompares++;
            $display("FAIL sub_5m7: display=%h ovf=%b, need FFFE/1", kp.display, kp.ovf);
        end
    endtask

    task automatic test_chain();
        int n;
        bit held_ok;
        do_reset();
        press_hex(4'h3);
        press_op(2'b00);
        press_hex(4'h4);
        press_op(2'b01);
        vectors++;
        if (kp.display !== 16'h0007 || kp.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL chain_add: display=%h busy=%b, need 0007/0", kp.display, kp.busy);
        end
        press_hex(4'h2);
        press_eq();
        wait_busy(16'h0002, 1'b0, n, held_ok);
        vectors++;
        if (kp.display !== 16'h000E || n != 17 || !held_ok) begin
            miscompares++;
            $display("FAIL chain_mul: display=%h cycles=%0d held=%b, need 000E/17/1", kp.display, n, held_ok);
        end
    endtask

    task automatic test_priority();
        do_reset();
        press_hex(4'h5);
        @(negedge clock); kp.newop = 1'b1; kp.opcode = 2'b00; kp.newhex = 1'b1; kp.hexcode = 4'h9;
        @(negedge clock); kp.newop = 1'b0; kp.newhex = 1'b0;
        vectors++;
        if (kp.display !== 16'h0005) begin
            miscompares++;
            $display("FAIL prio_op_hex: display=%h, need 0005", kp.display);
        end
        press_hex(4'h3);
        @(negedge clock); kp.eq = 1'b1; kp.newhex = 1'b1; kp.hexcode = 4'hA;
        @(negedge clock); kp.eq = 1'b0; kp.newhex = 1'b0;
        vectors++;
        if (kp.display !== 16'h0008) begin
            miscompares++;
            $display("FAIL prio_eq_hex: display=%h, need 0008", kp.display);
        end
    endtask

    task automatic test_reset_in_mul();
        do_reset();
        enter(16'hFFFF, 4);
        press_op(2'b01);
        enter(16'hFFFF, 4);
        press_eq();
        repeat (4) @(negedge clock);
        vectors++;
        if (kp.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL mul_running: busy=%b, need 1", kp.busy);
        end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        vectors++;
        if (kp.display !== 16'h0000 || kp.busy !== 1'b0 || kp.ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_abort: display=%h busy=%b ovf=%b, need 0000/0/0", kp.display, kp.busy, kp.ovf);
        end
        press_hex(4'h1);
        press_op(2'b00);
        press_hex(4'h1);
        press_eq();
        vectors++;
        if (kp.display !== 16'h0002 || kp.ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_add: display=%h ovf=%b, need 0002/0", kp.display, kp.ovf);
        end
    endtask

    initial begin
        kp.newhex  = 1'b0;
        kp.hexcode = 4'h0;
        kp.newop   = 1'b0;
        kp.opcode  = 2'b00;
        kp.eq      = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        test_reset();
        test_digits();
        test_add_repeat();
        test_add_carry();
        test_multiply();
        test_subtract();
        test_chain();
        test_priority();
        test_reset_in_mul();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
